// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS cores: opcodes, funct codes, multicycle FSM
// states and the select/ALU-function encodings driven into the datapath.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALURESULT = 2'b00;
    localparam logic [1:0] PC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_JUMP      = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type funct codes the ALU can actually execute.
    function automatic logic rtype_funct_ok(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Unified memory port between the control unit and instruction/data memory.
// Handshake: mem_req is the request valid and mem_ready the completion; an access
// completes in the cycle both are high, and iord/memwrite hold steady until then.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic iord;
    logic memwrite;
    logic mem_ready;

    modport master (output mem_req, output iord, output memwrite, input mem_ready);
    modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's aluop plus the R-type funct field to an ALU function.
module alu_dec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback with memory stalls, plus the ALU decoder. All outputs are combinational.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [5:0]                     op,
    input  logic [5:0]                     funct,
    input  logic                           zero,
    mips_multicycle_ctrl_if.master         mem,
    output logic                           irwrite,
    output logic                           regdst,
    output logic                           memtoreg,
    output logic                           regwrite,
    output logic                           alusrca,
    output logic [1:0]                     alusrcb,
    output logic [2:0]                     alucontrol,
    output logic [1:0]                     pcsrc,
    output logic                           pcen,
    output logic                           illegal_op,
    output state_t                         state_dbg
);

    state_t     state;
    state_t     next_state;
    logic       op_ok;
    logic [1:0] aluop;
    logic [2:0] alu_fn;
    logic       pcwrite;
    logic       branch;
    logic       c_mem_req, c_iord, c_memwrite, c_irwrite;
    logic       c_regdst, c_memtoreg, c_regwrite, c_alusrca, c_illegal;
    logic [1:0] c_alusrcb, c_pcsrc;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_RTYPE: op_ok = rtype_funct_ok(funct);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = mem.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = op_ok ? EXECUTE : FETCH;
                    OP_BEQ:       next_state = BEQ;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = mem.mem_ready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = mem.mem_ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            BEQ:     next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        c_mem_req  = 1'b0;
        c_iord     = 1'b0;
        c_memwrite = 1'b0;
        c_irwrite  = 1'b0;
        c_regdst   = 1'b0;
        c_memtoreg = 1'b0;
        c_regwrite = 1'b0;
        c_alusrca  = 1'b0;
        c_alusrcb  = SRCB_B;
        c_pcsrc    = PC_ALURESULT;
        c_illegal  = 1'b0;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        case (state)
            FETCH: begin
                c_mem_req = 1'b1;
                c_alusrcb = SRCB_FOUR;
                c_irwrite = mem.mem_ready;
                pcwrite   = mem.mem_ready;
            end
            DECODE: begin
                c_alusrcb = SRCB_IMM_SH2;
                c_illegal = ~op_ok;
            end
            MEMADR: begin
                c_alusrca = 1'b1;
                c_alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                c_mem_req = 1'b1;
                c_iord    = 1'b1;
            end
            MEMWB: begin
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
            end
            MEMWR: begin
                c_mem_req  = 1'b1;
                c_iord     = 1'b1;
                c_memwrite = 1'b1;
            end
            EXECUTE: begin
                c_alusrca = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            ALUWB: begin
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
            end
            BEQ: begin
                c_alusrca = 1'b1;
                aluop     = ALUOP_SUB;
                c_pcsrc   = PC_ALUOUT;
                branch    = 1'b1;
            end
            ADDIEX: begin
                c_alusrca = 1'b1;
                c_alusrcb = SRCB_IMM;
            end
            ADDIWB: c_regwrite = 1'b1;
            JUMP: begin
                c_pcsrc = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alu_fn)
    );

    // Reset gates every output so a held reset cannot write PC, IR, regs or memory.
    assign mem.mem_req  = rst ? 1'b0 : c_mem_req;
    assign mem.iord     = rst ? 1'b0 : c_iord;
    assign mem.memwrite = rst ? 1'b0 : c_memwrite;
    assign irwrite      = rst ? 1'b0 : c_irwrite;
    assign regdst       = rst ? 1'b0 : c_regdst;
    assign memtoreg     = rst ? 1'b0 : c_memtoreg;
    assign regwrite     = rst ? 1'b0 : c_regwrite;
    assign alusrca      = rst ? 1'b0 : c_alusrca;
    assign alusrcb      = rst ? 2'b00 : c_alusrcb;
    assign alucontrol   = rst ? 3'b000 : alu_fn;
    assign pcsrc        = rst ? 2'b00 : c_pcsrc;
    assign pcen         = rst ? 1'b0 : (pcwrite | (branch & zero));
    assign illegal_op   = rst ? 1'b0 : c_illegal;
    assign state_dbg    = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle control unit: a per-cycle vector table plus
// hand-written sequences for memory stalls and the illegal-op pulse.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    // Output word order: mem_req iord memwrite irwrite regdst memtoreg regwrite
    // alusrca alusrcb[1:0] alucontrol[2:0] pcsrc[1:0] pcen illegal_op
    localparam logic [16:0] O_ZERO     = 17'b0_0_0_0_0_0_0_0_00_000_00_0_0;
    localparam logic [16:0] O_FETCH    = 17'b1_0_0_1_0_0_0_0_01_010_00_1_0;
    localparam logic [16:0] O_FSTALL   = 17'b1_0_0_0_0_0_0_0_01_010_00_0_0;
    localparam logic [16:0] O_DECODE   = 17'b0_0_0_0_0_0_0_0_11_010_00_0_0;
    localparam logic [16:0] O_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_11_010_00_0_1;
    localparam logic [16:0] O_MEMADR   = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [16:0] O_MEMRD    = 17'b1_1_0_0_0_0_0_0_00_010_00_0_0;
    localparam logic [16:0] O_MEMWB    = 17'b0_0_0_0_0_1_1_0_00_010_00_0_0;
    localparam logic [16:0] O_MEMWR    = 17'b1_1_1_0_0_0_0_0_00_010_00_0_0;
    localparam logic [16:0] O_EXEC_SLT = 17'b0_0_0_0_0_0_0_1_00_111_00_0_0;
    localparam logic [16:0] O_EXEC_AND = 17'b0_0_0_0_0_0_0_1_00_000_00_0_0;
    localparam logic [16:0] O_EXEC_SUB = 17'b0_0_0_0_0_0_0_1_00_110_00_0_0;
    localparam logic [16:0] O_ALUWB    = 17'b0_0_0_0_1_0_1_0_00_010_00_0_0;
    localparam logic [16:0] O_BEQ_T    = 17'b0_0_0_0_0_0_0_1_00_110_01_1_0;
    localparam logic [16:0] O_BEQ_NT   = 17'b0_0_0_0_0_0_0_1_00_110_01_0_0;
    localparam logic [16:0] O_ADDIWB   = 17'b0_0_0_0_0_0_1_0_00_010_00_0_0;
    localparam logic [16:0] O_JUMP     = 17'b0_0_0_0_0_0_0_0_00_010_10_1_0;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        mr;
        logic        chk;
        state_t      st;
        logic [16:0] out;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    state_t      state_dbg;

    vec_t        vecs[$];
    int          tests = 0;
    int          fails = 0;

    mips_multicycle_ctrl_if mem ();

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem        (mem),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] outs();
        return {mem.mem_req, mem.iord, mem.memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic m, input logic c, input state_t s, input logic [16:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.mr = m; v.chk = c; v.st = s; v.out = e;
        vecs.push_back(v);
    endtask

    initial begin
        int     mw_cycles;
        int     pulses;
        int     back_to_back;
        logic   prev_ill;
        state_t st_after;

        // Reset held 3 cycles; state is unknown until the first edge.
        add(1, OP_LW, 0, 0, 1, 0, FETCH, O_ZERO);
        add(1, OP_LW, 0, 0, 1, 1, FETCH, O_ZERO);
        add(1, OP_LW, 0, 0, 1, 1, FETCH, O_ZERO);
        // lw, no stalls: 5 cycles
        add(0, OP_LW, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_LW, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_LW, 0, 0, 1, 1, MEMADR, O_MEMADR);
        add(0, OP_LW, 0, 0, 1, 1, MEMRD,  O_MEMRD);
        add(0, OP_LW, 0, 0, 1, 1, MEMWB,  O_MEMWB);
        // R-type slt, and, sub
        add(0, OP_RTYPE, FN_SLT, 0, 1, 1, FETCH,   O_FETCH);
        add(0, OP_RTYPE, FN_SLT, 0, 1, 1, DECODE,  O_DECODE);
        add(0, OP_RTYPE, FN_SLT, 0, 1, 1, EXECUTE, O_EXEC_SLT);
        add(0, OP_RTYPE, FN_SLT, 0, 1, 1, ALUWB,   O_ALUWB);
        add(0, OP_RTYPE, FN_AND, 0, 1, 1, FETCH,   O_FETCH);
        add(0, OP_RTYPE, FN_AND, 0, 1, 1, DECODE,  O_DECODE);
        add(0, OP_RTYPE, FN_AND, 0, 1, 1, EXECUTE, O_EXEC_AND);
        add(0, OP_RTYPE, FN_AND, 0, 1, 1, ALUWB,   O_ALUWB);
        add(0, OP_RTYPE, FN_SUB, 0, 1, 1, FETCH,   O_FETCH);
        add(0, OP_RTYPE, FN_SUB, 0, 1, 1, DECODE,  O_DECODE);
        add(0, OP_RTYPE, FN_SUB, 0, 1, 1, EXECUTE, O_EXEC_SUB);
        add(0, OP_RTYPE, FN_SUB, 0, 1, 1, ALUWB,   O_ALUWB);
        // R-type with unsupported funct: 2 cycles
        add(0, OP_RTYPE, 6'b000000, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_RTYPE, 6'b000000, 0, 1, 1, DECODE, O_DEC_ILL);
        // beq taken and not taken
        add(0, OP_BEQ, 0, 1, 1, 1, FETCH,  O_FETCH);
        add(0, OP_BEQ, 0, 1, 1, 1, DECODE, O_DECODE);
        add(0, OP_BEQ, 0, 1, 1, 1, BEQ,    O_BEQ_T);
        add(0, OP_BEQ, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_BEQ, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_BEQ, 0, 0, 1, 1, BEQ,    O_BEQ_NT);
        // addi, j
        add(0, OP_ADDI, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_ADDI, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_ADDI, 0, 0, 1, 1, ADDIEX, O_MEMADR);
        add(0, OP_ADDI, 0, 0, 1, 1, ADDIWB, O_ADDIWB);
        add(0, OP_J, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_J, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_J, 0, 0, 1, 1, JUMP,   O_JUMP);
        // sw with 2 stall cycles in FETCH and 2 in MEMWR
        add(0, OP_SW, 0, 0, 0, 1, FETCH,  O_FSTALL);
        add(0, OP_SW, 0, 0, 0, 1, FETCH,  O_FSTALL);
        add(0, OP_SW, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_SW, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_SW, 0, 0, 1, 1, MEMADR, O_MEMADR);
        add(0, OP_SW, 0, 0, 0, 1, MEMWR,  O_MEMWR);
        add(0, OP_SW, 0, 0, 0, 1, MEMWR,  O_MEMWR);
        add(0, OP_SW, 0, 0, 1, 1, MEMWR,  O_MEMWR);
        // lw with one stall in MEMRD
        add(0, OP_LW, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_LW, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_LW, 0, 0, 1, 1, MEMADR, O_MEMADR);
        add(0, OP_LW, 0, 0, 0, 1, MEMRD,  O_MEMRD);
        add(0, OP_LW, 0, 0, 1, 1, MEMRD,  O_MEMRD);
        add(0, OP_LW, 0, 0, 1, 1, MEMWB,  O_MEMWB);
        // sw abandoned by reset in MEMWR
        add(0, OP_SW, 0, 0, 1, 1, FETCH,  O_FETCH);
        add(0, OP_SW, 0, 0, 1, 1, DECODE, O_DECODE);
        add(0, OP_SW, 0, 0, 1, 1, MEMADR, O_MEMADR);
        add(1, OP_SW, 0, 0, 0, 1, MEMWR,  O_ZERO);
        add(0, OP_SW, 0, 0, 1, 1, FETCH,  O_FETCH);
        // unsupported opcode
        add(0, 6'b111111, 0, 0, 1, 1, DECODE, O_DEC_ILL);
        add(0, 6'b111111, 0, 0, 1, 1, FETCH,  O_FETCH);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            op = vecs[i].op;
            funct = vecs[i].funct;
            zero = vecs[i].zero;
            mem.mem_ready = vecs[i].mr;
            #1;
            check($sformatf("row%0d_out", i), 32'(outs()), 32'(vecs[i].out));
            if (vecs[i].chk)
                check($sformatf("row%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            @(negedge clk);
        end

        // sw with mem_ready low for two MEMWR cycles: memwrite must last 3 cycles.
        rst = 1'b1; mem.mem_ready = 1'b1; zero = 1'b0;
        @(negedge clk);
        rst = 1'b0; op = OP_SW; funct = 6'b0;
        mw_cycles = 0;
        st_after = DECODE;
        for (int c = 0; c < 7; c++) begin
            mem.mem_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            #1;
            if (mem.memwrite) mw_cycles++;
            if (c == 6) st_after = state_dbg;
            @(negedge clk);
        end
        check("sw_memwrite_cycles", 32'(mw_cycles), 32'd3);
        check("sw_return_fetch", 32'(st_after), 32'(FETCH));

        // Unsupported opcode repeated: each DECODE pulses illegal_op for one cycle.
        rst = 1'b1; mem.mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; op = 6'b111111;
        pulses = 0; back_to_back = 0; prev_ill = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (illegal_op) pulses++;
            if (illegal_op && prev_ill) back_to_back++;
            prev_ill = illegal_op;
            @(negedge clk);
        end
        check("illegal_pulse_count", 32'(pulses), 32'd3);
        check("illegal_pulse_width", 32'(back_to_back), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
